// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding and
// default sizing.
package mux_rr_arbiter_pkg;

   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned DW_DEF   = 8;
   localparam int unsigned SELW_DEF = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotates the request vector so that the
// pointer position lands at bit 0, priority-encodes the lowest set bit and
// rotates the resulting offset back into an absolute requester index.
module mux_rr_arbiter_rr_pick
   import mux_rr_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned SELW = SELW_DEF
) (
   input  logic [NREQ-1:0] req,
   input  logic [SELW-1:0] ptr,
   output logic            any,
   output logic [SELW-1:0] win_idx
);

   logic [NREQ-1:0] w_rot;
   logic [SELW-1:0] w_ridx;
   logic [SELW-1:0] w_off;
   logic            w_found;

   // Rotate req so that requester ptr appears at bit 0 (modulo NREQ).
   always_comb begin
      w_rot  = '0;
      w_ridx = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_ridx   = SELW'((k + 32'(ptr)) % NREQ);
         w_rot[k] = req[w_ridx];
      end
   end

   // Priority-encode the lowest set bit of the rotated vector.
   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = SELW'(k);
         end
      end
   end

   assign any     = |req;
   assign win_idx = SELW'((32'(w_off) + 32'(ptr)) % NREQ);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared N:1 data mux. Captures the
// winning requester's data into an output register, pulses ack for one cycle
// and holds the item until the consumer accepts it.
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned SELW = SELW_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    ack,
   output logic               out_valid,
   output logic [DW-1:0]      out_data,
   output logic [SELW-1:0]    out_sel,
   input  logic               out_ready
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [SELW-1:0] r_ptr;
   logic            r_valid;
   logic [DW-1:0]   r_data;
   logic [SELW-1:0] r_sel;
   logic [NREQ-1:0] r_ack;

   logic            w_any;
   logic [SELW-1:0] w_win;
   logic [DW-1:0]   w_win_data;
   logic [NREQ-1:0] w_onehot;
   logic            w_capture;
   logic            w_xfer;

   mux_rr_arbiter_rr_pick #(
      .NREQ (NREQ),
      .SELW (SELW)
   ) u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .any     (w_any),
      .win_idx (w_win)
   );

   // Data mux slice and one-hot grant for the current winner.
   always_comb begin
      w_win_data = '0;
      w_onehot   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_win == SELW'(i)) begin
            w_win_data  = req_data[i*DW +: DW];
            w_onehot[i] = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state: capture moves to BUSY, consumer acceptance returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any)     w_state_nxt = BUSY;
         BUSY:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM outputs: capture and transfer strobes; req is ignored while BUSY.
   always_comb begin
      w_capture = 1'b0;
      w_xfer    = 1'b0;
      case (r_state)
         IDLE:    w_capture = w_any;
         BUSY:    w_xfer    = out_ready;
         default: ;
      endcase
   end

   // Output, ack and pointer registers; ack self-clears one cycle after capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ack   <= '0;
      end else begin
         r_ack <= '0;
         if (w_capture) begin
            r_data  <= w_win_data;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_ack   <= w_onehot;
         end
         if (w_xfer) begin
            r_valid <= 1'b0;
            r_ptr   <= (r_sel == SELW'(NREQ-1)) ? '0 : r_sel + 1'b1;
         end
      end
   end

   assign ack       = r_ack;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter. Stimulus pushes the expected captured
// item into a queue; a monitor pops it when out_valid rises and then checks
// hold stability, ack pulse width and transfer behaviour every cycle.
module tb_mux_rr_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 8;
   localparam int unsigned SELW = 2;

   typedef struct packed {
      logic [SELW-1:0] sel;
      logic [DW-1:0]   data;
   } item_t;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    ack;
   logic               out_valid;
   logic [DW-1:0]      out_data;
   logic [SELW-1:0]    out_sel;
   logic               out_ready;

   item_t exp_q[$];
   item_t cur;
   int    n_cmp   = 0;
   int    n_bad   = 0;
   int    n_items = 0;
   int    items_before;
   logic  prev_valid = 1'b0;
   logic  prev_ready = 1'b0;

   mux_rr_arbiter #(
      .NREQ (NREQ),
      .DW   (DW),
      .SELW (SELW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [DW-1:0] d);
      req_data[i*DW +: DW] = d;
   endtask

   task automatic push(input int s, input logic [DW-1:0] d);
      item_t it;
      it.sel  = SELW'(s);
      it.data = d;
      exp_q.push_back(it);
   endtask

   // Monitor: pop on capture, verify hold/ack/transfer every cycle.
   always @(negedge clk or posedge reset) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_item: got sel %0d data %0h expected none", out_sel, out_data);
               cur = '0;
            end else begin
               cur = exp_q.pop_front();
               n_items++;
               check("cap_sel", 32'(out_sel), 32'(cur.sel));
               check("cap_data", 32'(out_data), 32'(cur.data));
               check("cap_ack", 32'(ack), 32'(1) << cur.sel);
            end
         end else if (out_valid) begin
            check("hold_sel", 32'(out_sel), 32'(cur.sel));
            check("hold_data", 32'(out_data), 32'(cur.data));
            check("hold_ack", 32'(ack), 32'(0));
            if (prev_ready) check("xfer_missed", 32'(out_valid), 32'(0));
         end else begin
            check("idle_ack", 32'(ack), 32'(0));
            if (prev_valid && !prev_ready) check("item_dropped", 32'(out_valid), 32'(1));
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
      end
   end

   initial begin
      #100000;
      n_bad++;
      $display("FAIL timeout: simulation did not complete, expected finish before 100000");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      reset     = 1'b1;
      req       = '0;
      req_data  = '0;
      out_ready = 1'b0;
      tick(2);
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_sel", 32'(out_sel), 32'(0));
      check("rst_data", 32'(out_data), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      tick(1);

      // Single requester 2
      set_data(2, 8'hA5);
      req       = 4'b0100;
      out_ready = 1'b1;
      push(2, 8'hA5);
      tick(1);
      check("single_valid", 32'(out_valid), 32'(1));
      check("single_ack", 32'(ack), 32'(4'b0100));
      req = '0;
      tick(1);
      check("single_done_valid", 32'(out_valid), 32'(0));
      check("single_done_ack", 32'(ack), 32'(0));

      // ptr now 3: all requesting picks 3 first
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
      req = 4'b1111;
      push(3, 8'h13);
      tick(1);
      req = '0;
      tick(1);

      // Fresh reset, all requesting continuously: 0,1,2,3,0
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      req       = 4'b1111;
      out_ready = 1'b1;
      push(0, 8'h10);
      push(1, 8'h11);
      push(2, 8'h12);
      push(3, 8'h13);
      push(0, 8'h10);
      items_before = n_items;
      tick(9);
      req = '0;
      tick(1);
      check("rate_items", 32'(n_items - items_before), 32'(5));

      // Backpressure on requester 1 (ptr=1), req/data churn while BUSY
      set_data(1, 8'h3C);
      req       = 4'b0010;
      out_ready = 1'b0;
      push(1, 8'h3C);
      tick(1);
      req = 4'b1101;
      set_data(1, 8'hFF);
      set_data(0, 8'hEE);
      tick(5);
      out_ready = 1'b1;
      req       = '0;
      tick(1);
      check("bp_xfer_valid", 32'(out_valid), 32'(0));

      // Fairness after wrap: serve 2, then 1001 -> 3, then 1001 -> 0
      set_data(2, 8'h22);
      req = 4'b0100;
      push(2, 8'h22);
      tick(1);
      req = 4'b1001;
      set_data(0, 8'h0A);
      set_data(3, 8'h3B);
      push(3, 8'h3B);
      tick(2);
      push(0, 8'h0A);
      tick(2);
      req = '0;
      tick(1);

      // Asynchronous reset while BUSY with ack high
      set_data(1, 8'h77);
      req       = 4'b0010;
      out_ready = 1'b0;
      push(1, 8'h77);
      tick(1);
      req = '0;
      check("pre_rst_valid", 32'(out_valid), 32'(1));
      check("pre_rst_ack", 32'(ack), 32'(4'b0010));
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'(0));
      check("arst_ack", 32'(ack), 32'(0));
      check("arst_sel", 32'(out_sel), 32'(0));
      check("arst_data", 32'(out_data), 32'(0));
      #5;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
      req       = 4'b1111;
      out_ready = 1'b1;
      push(0, 8'h10);
      tick(1);
      req = '0;
      tick(1);

      // Idle stability with out_ready toggling (ptr=1 must survive)
      req = '0;
      for (int i = 0; i < 10; i++) begin
         out_ready = 1'(i % 2);
         tick(1);
         check("idle_valid", 32'(out_valid), 32'(0));
         check("idle_ack_direct", 32'(ack), 32'(0));
      end
      set_data(0, 8'h55);
      set_data(1, 8'h66);
      req       = 4'b0011;
      out_ready = 1'b1;
      push(1, 8'h66);
      tick(1);
      req = '0;
      tick(2);

      check("queue_empty", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared N:1 data mux feeding one downstream consumer.
- Each requester presents data with a level request. The block picks one requester fairly and drives the mux select. It captures the selected data into an output register and holds it until the consumer accepts it.
- Sits between multiple producers (e.g. register-file / ALU result sources) and a single shared bus.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per requester.
- SELW, 2, select width; must equal clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; bit i held high until ack[i].
- req_data  input  NREQ*DW  flattened data; requester i occupies bits [i*DW +: DW].
- ack  output  NREQ  one-hot, one-cycle pulse: requester's data has been captured.
- out_valid  output  1  out_data holds an item not yet accepted.
- out_data  output  DW  captured data from the granted requester.
- out_sel  output  SELW  index of the requester whose data is in out_data.
- out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high at a rising edge.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, ptr=0, ack=0, out_valid=0, out_data=0, out_sel=0.
  - The item in flight is discarded.
- States: IDLE, BUSY; two-state FSM, registered.
- IDLE, req==0: no change; outputs hold, ack=0.
- IDLE, req!=0, at the edge:
  - Pick winner w = first set bit of req scanning ptr, ptr+1, ..., wrapping modulo NREQ.
  - out_data <= req_data[w], out_sel <= w, out_valid <= 1, ack <= onehot(w), state <= BUSY.
- ack is high for exactly the one cycle after the capture edge. It is cleared at the next edge regardless of out_ready.
- BUSY, at the edge:
  - If out_ready=1: out_valid <= 0, ptr <= (out_sel+1) mod NREQ, state <= IDLE.
  - Otherwise hold out_data, out_sel and out_valid stable.
  - req is ignored in BUSY.
- Latency:
  - req to out_valid: 1 edge.
  - Minimum 2 cycles per item (capture, transfer).
  - After a transfer, the next capture occurs at the following edge at the earliest.
- Requester rule: after seeing ack[i], it may drop req[i], or present new data with req[i] held high. That new data is not sampled before the next IDLE edge.
- Fairness: a requester that was just served has lowest priority in the next arbitration. With all NREQ requesting continuously, service order is 0,1,2,...,NREQ-1,0,...
- Wrap-around: ptr increments modulo NREQ; out_sel = NREQ-1 sets ptr=0.
- Dropped requests: a request withdrawn before being granted is simply not seen. No memory of past requests is kept.
- out_ready while out_valid=0 is ignored.
- out_data is unchanged after transfer until the next capture. Consumers must qualify it with out_valid.

Decomposition:
- Shared package:
  - state encoding constants IDLE=1'b0, BUSY=1'b1.
  - default NREQ/DW values.
- Sub-module rr_pick: purely combinational.
  - Inputs: req, ptr. Outputs: any, win_idx.
  - Implements rotate, priority-encode, un-rotate.
- Top level holds the FSM, ptr and the output/ack registers, and performs the data-mux slice.

Test Plan:
- Single requester: reset, then req=4'b0100 with data[2]=8'hA5, out_ready=1.
  - Next cycle: out_valid=1, out_data=8'hA5, out_sel=2, ack=4'b0100.
  - Following cycle: out_valid=0, ack=0, ptr=3.
- All request, out_ready=1, data[i]=8'h10+i: out_sel sequence 0,1,2,3,0 with out_data 8'h10..8'h13,8'h10; one item every 2 cycles.
- Backpressure: capture from req[1] with out_ready=0 for 5 cycles.
  - out_valid, out_data and out_sel stay stable.
  - ack pulses only once.
  - Changing req/req_data in BUSY has no effect; transfer completes on the first edge with out_ready=1.
- Fairness after wrap: ptr=3 (last served 2), req=4'b1001 -> winner 3. Next arbitration, req=4'b1001 -> winner 0.
- Reset mid-operation: assert reset asynchronously (between edges) while BUSY with out_valid=1.
  - out_valid, ack and out_sel drop immediately without a clock.
  - After release, req=4'b1111 -> winner 0.
- Idle stability: req=0 for 10 cycles with out_ready toggling -> out_valid=0, ack=0, no state change.
